// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel debouncer for push-buttons and sensors.
// Each channel synchronises its raw pin, normalises polarity so 1 = pressed,
// and accepts a level change only after SETTLE_TIME stable cycles. It emits a
// clean level plus one-cycle press/release strobes.
// Build option DEBOUNCE_LONG_PRESS_EN adds a per-channel long-press strobe;
// without it long_pulse is tied low and no long counters exist.
module debounce_bank #(
  parameter int CHANNELS    = 4,
  parameter int SETTLE_TIME = 500000,
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2,
  parameter int ACTIVE_LOW  = 1,
  parameter int LONG_TIME   = 50000000,
  parameter int LONG_W      = 26
) (
  input  logic                clk_50_mhz,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] long_pulse,
  output logic                any_active,
  output logic                busy
);

  localparam logic             INACTIVE_RAW = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_TIME - 1);

  typedef enum logic {IDLE, SETTLING} state_t;

  logic [CHANNELS-1:0] level_nxt;
  logic [CHANNELS-1:0] busy_nxt;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync;
    logic                   pressed;
    logic                   candidate;
    logic                   level_q;
    logic                   press_q;
    logic                   release_q;
    logic                   long_q;
    logic                   accept;
    logic [CNT_W-1:0]       cnt;
    state_t                 state;

    // Synchroniser chain; reset parks it at the idle pin level so no false press appears
    always_ff @(posedge clk_50_mhz) begin
      if (!rst_n) begin
        sync <= {SYNC_STAGES{INACTIVE_RAW}};
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], btn_in[i]};
      end
    end

    assign pressed = sync[SYNC_STAGES-1] ^ INACTIVE_RAW;

    // The candidate has been stable long enough and is about to become the level
    assign accept       = (state == SETTLING) && (pressed == candidate) && (cnt == SETTLE_LAST);
    assign level_nxt[i] = accept ? candidate : level_q;
    assign busy_nxt[i]  = (pressed != level_nxt[i]);

    // Settle FSM: track a candidate level and accept it after an unbroken stable run
    always_ff @(posedge clk_50_mhz) begin
      if (!rst_n) begin
        state     <= IDLE;
        candidate <= 1'b0;
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        case (state)
          IDLE: begin
            if (pressed != level_q) begin
              candidate <= pressed;
              cnt       <= '0;
              state     <= SETTLING;
            end
          end
          SETTLING: begin
            if (pressed != candidate) begin
              candidate <= pressed;
              cnt       <= '0;
              if (pressed == level_q) begin
                state <= IDLE;
              end
            end else if (accept) begin
              level_q   <= candidate;
              press_q   <= candidate;
              release_q <= ~candidate;
              cnt       <= '0;
              state     <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_TIME - 1);
    localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_TIME);

    logic [LONG_W-1:0] lcnt;

    // Hold timer: fires once per press, then parks at LONG_SAT until release
    always_ff @(posedge clk_50_mhz) begin
      if (!rst_n) begin
        lcnt   <= '0;
        long_q <= 1'b0;
      end else begin
        long_q <= 1'b0;
        if (!level_q) begin
          lcnt <= '0;
        end else if (lcnt == LONG_LAST) begin
          long_q <= 1'b1;
          lcnt   <= LONG_SAT;
        end else if (lcnt != LONG_SAT) begin
          lcnt <= lcnt + 1'b1;
        end
      end
    end
`else
    assign long_q = 1'b0;
`endif

    assign level_out[i]     = level_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
    assign long_pulse[i]    = long_q;
  end

  // Summary flags taken from next-state values so they line up with level_out
  always_ff @(posedge clk_50_mhz) begin
    if (!rst_n) begin
      any_active <= 1'b0;
      busy       <= 1'b0;
    end else begin
      any_active <= |level_nxt;
      busy       <= |busy_nxt;
    end
  end

endmodule
